// File: rtl/ahb_wait_sram.sv
// rtl/ahb_wait_sram.sv - AHB-Lite SRAM subordinate with programmable wait states and ERROR response
//
// Single-port 32-bit SRAM behind an AHB-Lite subordinate interface. Every accepted transfer gets
// WAIT_STATES stalled cycles followed by an OKAY cycle. An illegal transfer gets the two-cycle
// ERROR response instead and never touches memory.
//
// Ports:
//   clk        clock, rising edge
//   nRST       asynchronous active-low reset
//   HSEL       subordinate select
//   HREADY     bus ready (previous data phase complete)
//   HTRANS     transfer type; bit 1 set means NONSEQ/SEQ
//   HWRITE     1 = write
//   HSIZE      transfer size, 0..2 legal
//   HADDR      byte address
//   HWDATA     write data (data phase)
//   HWSTRB     byte-lane write enables (data phase)
//   HRDATA     read data, valid during the OKAY cycle of a read, zero otherwise
//   HREADYOUT  subordinate ready
//   HRESP      0 OKAY, 1 ERROR
module ahb_wait_sram #(
    parameter int unsigned DEPTH       = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int unsigned WAIT_STATES = 0
) (
    input  logic        clk,
    input  logic        nRST,
    input  logic        HSEL,
    input  logic        HREADY,
    input  logic [1:0]  HTRANS,
    input  logic        HWRITE,
    input  logic [2:0]  HSIZE,
    input  logic [31:0] HADDR,
    input  logic [31:0] HWDATA,
    input  logic [3:0]  HWSTRB,
    output logic [31:0] HRDATA,
    output logic        HREADYOUT,
    output logic        HRESP
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;
    localparam logic [CW-1:0] WS_CNT = CW'(WAIT_STATES);
    // Window size in bytes, kept 33 bits wide so BASE_ADDR + span cannot overflow.
    localparam logic [32:0] SPAN = 33'(DEPTH) << 2;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_WAIT = 3'd1,
        S_OKAY = 3'd2,
        S_ERR1 = 3'd3,
        S_ERR2 = 3'd4
    } state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic            write_q, write_d;
    logic [CW-1:0]   wcnt_q, wcnt_d;

    logic [31:0]     mem [DEPTH];

    logic            accept;
    logic            err_flag;
    logic            misaligned;
    logic [32:0]     offset;
    logic            mem_we;
    state_t          first_state;

    // HTRANS[0] only distinguishes SEQ from NONSEQ (or BUSY from IDLE); both are treated alike.
    logic            unused_htrans0;
    assign unused_htrans0 = HTRANS[0];

    // Address-phase decode. An address below BASE_ADDR wraps the 33-bit difference to a value
    // with bit 32 set, so one unsigned compare covers both ends of the window.
    always_comb begin
        offset     = {1'b0, HADDR} - {1'b0, BASE_ADDR};
        misaligned = ((HSIZE == 3'd1) && HADDR[0]) ||
                     ((HSIZE == 3'd2) && (HADDR[1:0] != 2'b00));
        err_flag   = (offset >= SPAN) || (HSIZE > 3'd2) || misaligned;
        accept     = HSEL && HREADY && HTRANS[1];
        if (err_flag) begin
            first_state = S_ERR1;
        end else if (WAIT_STATES > 0) begin
            first_state = S_WAIT;
        end else begin
            first_state = S_OKAY;
        end
    end

    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            write_q <= 1'b0;
            wcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            write_q <= write_d;
            wcnt_q  <= wcnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        write_d   = write_q;
        wcnt_d    = wcnt_q;
        HREADYOUT = 1'b1;
        HRESP     = 1'b0;
        unique case (state_q)
            // The last cycle of a data phase doubles as the next address phase.
            S_IDLE, S_OKAY, S_ERR2: begin
                HRESP   = (state_q == S_ERR2);
                state_d = S_IDLE;
                if (accept) begin
                    state_d = first_state;
                    addr_d  = HADDR[AW+1:2];
                    write_d = HWRITE;
                    wcnt_d  = '0;
                end
            end
            S_WAIT: begin
                HREADYOUT = 1'b0;
                // Counter stops at WAIT_STATES on leaving, so it never wraps.
                wcnt_d    = wcnt_q + CW'(1);
                if ((wcnt_q + CW'(1)) == WS_CNT) begin
                    state_d = S_OKAY;
                end
            end
            S_ERR1: begin
                HREADYOUT = 1'b0;
                HRESP     = 1'b1;
                state_d   = S_ERR2;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Writes land on the edge that ends OKAY. A reset during the data phase forces state_q to
    // IDLE immediately, so an aborted write never reaches this point.
    assign mem_we = (state_q == S_OKAY) && write_q;

    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int i = 0; i < 4; i++) begin
                if (HWSTRB[i]) begin
                    mem[addr_q][8*i +: 8] <= HWDATA[8*i +: 8];
                end
            end
        end
    end

    assign HRDATA = ((state_q == S_OKAY) && !write_q) ? mem[addr_q] : 32'h0;

endmodule

// File: tb/tb_ahb_wait_sram.sv
// tb/tb_ahb_wait_sram.sv - self-checking bench for ahb_wait_sram (2 wait states and 0 wait states)
module tb_ahb_wait_sram;

    localparam int          DEPTH = 1024;
    localparam logic [31:0] BASE0 = 32'h0000_0000;
    localparam logic [31:0] BASE1 = 32'h0001_0000;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        nRST;
    logic [1:0]  hsel;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [31:0] haddr;
    logic [31:0] hwdata;
    logic [3:0]  hwstrb;
    logic        cur;

    logic [31:0] hrdata0, hrdata1;
    logic        hro0, hro1, hresp0, hresp1;
    logic        hready_bus;
    logic        obs_ro, obs_resp;
    logic [31:0] obs_rd;

    int checks   = 0;
    int failures = 0;

    // Behavioural memory model with per-byte "written" flags (the SRAM is never reset).
    logic [31:0] mem_m [2][DEPTH];
    logic [3:0]  kn    [2][DEPTH];

    assign hready_bus = cur ? hro1 : hro0;
    assign obs_ro     = cur ? hro1 : hro0;
    assign obs_resp   = cur ? hresp1 : hresp0;
    assign obs_rd     = cur ? hrdata1 : hrdata0;

    ahb_wait_sram #(.DEPTH(DEPTH), .BASE_ADDR(BASE0), .WAIT_STATES(2)) u_ws2 (
        .clk(clk), .nRST(nRST), .HSEL(hsel[0]), .HREADY(hready_bus), .HTRANS(htrans),
        .HWRITE(hwrite), .HSIZE(hsize), .HADDR(haddr), .HWDATA(hwdata), .HWSTRB(hwstrb),
        .HRDATA(hrdata0), .HREADYOUT(hro0), .HRESP(hresp0)
    );

    ahb_wait_sram #(.DEPTH(DEPTH), .BASE_ADDR(BASE1), .WAIT_STATES(0)) u_ws0 (
        .clk(clk), .nRST(nRST), .HSEL(hsel[1]), .HREADY(hready_bus), .HTRANS(htrans),
        .HWRITE(hwrite), .HSIZE(hsize), .HADDR(haddr), .HWDATA(hwdata), .HWSTRB(hwstrb),
        .HRDATA(hrdata1), .HREADYOUT(hro1), .HRESP(hresp1)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] base_of(input logic s);
        return s ? BASE1 : BASE0;
    endfunction

    function automatic bit is_err(input logic s, input logic [31:0] a, input logic [2:0] sz);
        logic [31:0] b;
        b = base_of(s);
        if (a < b) return 1'b1;
        if ((a - b) >= 32'(DEPTH * 4)) return 1'b1;
        if (sz > 3'd2) return 1'b1;
        if (sz == 3'd1 && a[0]) return 1'b1;
        if (sz == 3'd2 && a[1:0] != 2'b00) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_write(input logic s, input int idx, input logic [31:0] wd,
                               input logic [3:0] st);
        for (int b = 0; b < 4; b++) begin
            if (st[b]) begin
                mem_m[s][idx][8*b +: 8] = wd[8*b +: 8];
                kn[s][idx][b] = 1'b1;
            end
        end
    endtask

    function automatic logic [31:0] known_mask(input logic s, input int idx);
        logic [31:0] m;
        m = 32'h0;
        for (int b = 0; b < 4; b++) begin
            if (kn[s][idx][b]) m[8*b +: 8] = 8'hFF;
        end
        return m;
    endfunction

    // One isolated transfer: address phase, full data phase checked cycle by cycle.
    task automatic xfer(input logic s, input logic wr, input logic [31:0] a, input logic [2:0] sz,
                        input logic [31:0] wd, input logic [3:0] st, input string tag);
        bit          e;
        int          w;
        int          idx;
        logic [31:0] m;
        e   = is_err(s, a, sz);
        w   = s ? 0 : 2;
        idx = e ? 0 : int'((a - base_of(s)) >> 2);
        @(negedge clk);
        cur    = s;
        hsel   = s ? 2'b10 : 2'b01;
        htrans = 2'b10;
        hwrite = wr;
        hsize  = sz;
        haddr  = a;
        @(negedge clk);
        hsel   = 2'b00;
        htrans = 2'b00;
        hwdata = wd;
        hwstrb = st;
        if (e) begin
            check({tag, "_err1_ro"},   32'(obs_ro),   32'd0);
            check({tag, "_err1_resp"}, 32'(obs_resp), 32'd1);
            @(negedge clk);
            check({tag, "_err2_ro"},   32'(obs_ro),   32'd1);
            check({tag, "_err2_resp"}, 32'(obs_resp), 32'd1);
        end else begin
            for (int c = 0; c < w; c++) begin
                check($sformatf("%s_wait%0d_ro", tag, c),   32'(obs_ro),   32'd0);
                check($sformatf("%s_wait%0d_resp", tag, c), 32'(obs_resp), 32'd0);
                check($sformatf("%s_wait%0d_rd", tag, c),   obs_rd,        32'd0);
                @(negedge clk);
            end
            check({tag, "_ok_ro"},   32'(obs_ro),   32'd1);
            check({tag, "_ok_resp"}, 32'(obs_resp), 32'd0);
            if (wr) begin
                check({tag, "_ok_rd"}, obs_rd, 32'd0);
                model_write(s, idx, wd, st);
            end else begin
                m = known_mask(s, idx);
                check({tag, "_rdata"}, obs_rd & m, mem_m[s][idx] & m);
            end
        end
    endtask

    initial begin
        logic        rs, rwr;
        logic [2:0]  rsz;
        logic [31:0] ra;

        for (int i = 0; i < DEPTH; i++) begin
            kn[0][i] = 4'h0;
            kn[1][i] = 4'h0;
            mem_m[0][i] = 32'h0;
            mem_m[1][i] = 32'h0;
        end
        nRST = 1'b0; cur = 1'b0; hsel = 2'b00; htrans = 2'b00; hwrite = 1'b0;
        hsize = 3'd2; haddr = 32'h0; hwdata = 32'h0; hwstrb = 4'h0;
        repeat (2) @(negedge clk);
        check("rst_ro0",   32'(hro0),   32'd1);
        check("rst_resp0", 32'(hresp0), 32'd0);
        check("rst_rd0",   hrdata0,     32'd0);
        check("rst_ro1",   32'(hro1),   32'd1);
        check("rst_resp1", 32'(hresp1), 32'd0);
        check("rst_rd1",   hrdata1,     32'd0);
        nRST = 1'b1;

        // Two wait states: full write, read back, partial-strobe overwrite.
        xfer(1'b0, 1'b1, 32'h10, 3'd2, 32'hDEADBEEF, 4'hF, "t1_wr");
        xfer(1'b0, 1'b0, 32'h10, 3'd2, 32'h0,        4'h0, "t1_rd");
        check("t1_model", mem_m[0][4], 32'hDEADBEEF);
        xfer(1'b0, 1'b1, 32'h10, 3'd2, 32'h11223344, 4'b0101, "t2_wr");
        xfer(1'b0, 1'b0, 32'h10, 3'd2, 32'h0,        4'h0,    "t2_rd");
        check("t2_model", mem_m[0][4], 32'hDE22BE44);

        // One past the window errors; the last word must survive.
        xfer(1'b0, 1'b1, 32'(DEPTH * 4 - 4), 3'd2, 32'h12345678, 4'hF, "t3_last_wr");
        xfer(1'b0, 1'b1, 32'(DEPTH * 4),     3'd2, 32'hFFFFFFFF, 4'hF, "t3_oob_wr");
        xfer(1'b0, 1'b0, 32'(DEPTH * 4 - 4), 3'd2, 32'h0,        4'h0, "t3_last_rd");

        // Zero wait states: 16 pipelined writes then 16 pipelined reads, one beat per cycle.
        @(negedge clk);
        cur = 1'b1;
        for (int i = 0; i <= 16; i++) begin
            if (i > 0) begin
                check($sformatf("t4_wr%0d_ro", i - 1),   32'(obs_ro),   32'd1);
                check($sformatf("t4_wr%0d_resp", i - 1), 32'(obs_resp), 32'd0);
                hwdata = 32'(i);
                hwstrb = 4'hF;
                model_write(1'b1, 16 + i - 1, 32'(i), 4'hF);
            end
            if (i < 16) begin
                hsel = 2'b10; htrans = 2'b10; hwrite = 1'b1; hsize = 3'd2;
                haddr = BASE1 + 32'h40 + 32'(4 * i);
            end else begin
                hsel = 2'b00; htrans = 2'b00;
            end
            @(negedge clk);
        end
        for (int i = 0; i <= 16; i++) begin
            if (i > 0) begin
                check($sformatf("t4_rd%0d_ro", i - 1), 32'(obs_ro), 32'd1);
                check($sformatf("t4_rd%0d_data", i - 1), obs_rd, 32'(i));
            end
            if (i < 16) begin
                hsel = 2'b10; htrans = 2'b10; hwrite = 1'b0; hsize = 3'd2;
                haddr = BASE1 + 32'h40 + 32'(4 * i);
            end else begin
                hsel = 2'b00; htrans = 2'b00;
            end
            @(negedge clk);
        end

        // Reset during the wait states of a write aborts it.
        xfer(1'b0, 1'b1, 32'h20, 3'd2, 32'h0BADF00D, 4'hF, "t5_pre_wr");
        @(negedge clk);
        cur = 1'b0; hsel = 2'b01; htrans = 2'b10; hwrite = 1'b1; hsize = 3'd2; haddr = 32'h20;
        @(negedge clk);
        hsel = 2'b00; htrans = 2'b00; hwdata = 32'hA5A5A5A5; hwstrb = 4'hF;
        check("t5_wait_ro", 32'(obs_ro), 32'd0);
        nRST = 1'b0;
        #1;
        check("t5_rst_ro",   32'(obs_ro),   32'd1);
        check("t5_rst_resp", 32'(obs_resp), 32'd0);
        check("t5_rst_rd",   obs_rd,        32'd0);
        @(negedge clk);
        nRST = 1'b1;
        xfer(1'b0, 1'b0, 32'h20, 3'd2, 32'h0, 4'h0, "t5_rd");

        // IDLE/BUSY with HSEL=1 is a zero-wait OKAY no-op, even with write data on the bus.
        @(negedge clk);
        cur = 1'b0;
        for (int c = 0; c < 5; c++) begin
            hsel = 2'b01; htrans = (c % 2 == 1) ? 2'b01 : 2'b00; hwrite = 1'b1;
            hsize = 3'd2; haddr = 32'h10; hwdata = 32'hCAFEF00D; hwstrb = 4'hF;
            @(negedge clk);
            check($sformatf("t6_idle%0d_ro", c),   32'(obs_ro),   32'd1);
            check($sformatf("t6_idle%0d_resp", c), 32'(obs_resp), 32'd0);
            check($sformatf("t6_idle%0d_rd", c),   obs_rd,        32'd0);
        end
        hsel = 2'b00; htrans = 2'b00;
        xfer(1'b0, 1'b0, 32'h10, 3'd2, 32'h0, 4'h0, "t6_rd");
        xfer(1'b0, 1'b0, 32'h10, 3'd3, 32'h0, 4'h0, "t6_hsize3");
        xfer(1'b1, 1'b1, BASE1 - 32'd4, 3'd2, 32'h1, 4'hF, "t6_below_base");
        xfer(1'b1, 1'b1, BASE1 + 32'h42, 3'd2, 32'h1, 4'hF, "t6_misalign");

        // Randomized single transfers against the model, including window edges and bad sizes.
        for (int n = 0; n < 80; n++) begin
            rs  = 1'($urandom_range(0, 1));
            rwr = 1'($urandom_range(0, 1));
            rsz = 3'($urandom_range(0, 3));
            case ($urandom_range(0, 9))
                0:       ra = base_of(rs) - 32'd4;
                1:       ra = base_of(rs) + 32'(DEPTH * 4);
                2:       ra = base_of(rs) + 32'(DEPTH * 4 - 4);
                default: ra = base_of(rs) + 32'($urandom_range(0, 31) * 4) + 32'($urandom_range(0, 3));
            endcase
            if ($urandom_range(0, 7) != 0 && rsz <= 3'd2) begin
                ra = ra & ~((32'd1 << rsz) - 32'd1);
            end
            xfer(rs, rwr, ra, rsz, $urandom, 4'($urandom_range(0, 15)), $sformatf("rnd%0d", n));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
